tray_plant: RTL

TRAY_PLANT -- requirements
Module: tray_plant

---
 rtl/tray_pkg.sv | 20 ++
 rtl/tray_sat_add.sv | 32 +++
 rtl/tray_plant.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tray_pkg.sv
// Shared constants for the tray plant model: motion-state encoding and default widths.
package tray_pkg;

    localparam int CUR_W_DEF      = 4;
    localparam int ACC_W_DEF      = 8;
    localparam int VEL_W_DEF      = 16;
    localparam int H_W_DEF        = 32;
    localparam int MASS_SHIFT_DEF = 0;
    localparam int GRAV_DEF       = 10;
    localparam int DAMP_SHIFT_DEF = 4;

    typedef enum logic [2:0] {
        FLOOR = 3'd0,
        RISE  = 3'd1,
        FALL  = 3'd2,
        HOVER = 3'd3,
        CEIL  = 3'd4
    } tray_state_e;

endpackage

// File: rtl/tray_sat_add.sv
// Signed add with optional arithmetic right shift of the sum, saturated to OUT_W bits.
module tray_sat_add #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [OUT_W-1:0] y
);

    // Work width holds the full sum and is never narrower than the output.
    localparam int X_W = (IN_W + 1 > OUT_W) ? IN_W + 1 : OUT_W;

    localparam logic signed [X_W-1:0] MAX_V = {{(X_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [X_W-1:0] MIN_V = ~MAX_V;

    logic signed [X_W-1:0] sum;
    logic signed [X_W-1:0] shd;

    assign sum = X_W'(a) + X_W'(b);
    assign shd = sum >>> SHIFT;

    always_comb begin
        y = shd[OUT_W-1:0];
        if (shd > MAX_V)
            y = MAX_V[OUT_W-1:0];
        else if (shd < MIN_V)
            y = MIN_V[OUT_W-1:0];
    end

endmodule

// File: rtl/tray_plant.sv
// Discrete-time tray lift plant: force -> accel -> velocity -> height, one stage per step.
// Optional velocity damping is enabled by defining TRAY_DAMPING_EN.
module tray_plant
    import tray_pkg::*;
#(
    parameter int             CUR_W      = CUR_W_DEF,
    parameter int             ACC_W      = ACC_W_DEF,
    parameter int             VEL_W      = VEL_W_DEF,
    parameter int             H_W        = H_W_DEF,
    parameter int             MASS_SHIFT = MASS_SHIFT_DEF,
    parameter int             GRAV       = GRAV_DEF,
    parameter logic [H_W-1:0] H_MAX      = {H_W{1'b1}},
    parameter int             DAMP_SHIFT = DAMP_SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step,
    input  logic [CUR_W-1:0]        icou,
    output logic [H_W-1:0]          tray_height,
    output logic signed [VEL_W-1:0] tray_vel,
    output logic signed [ACC_W-1:0] tray_acc,
    output logic                    at_floor,
    output logic                    at_ceil,
    output logic [2:0]              state
);

    localparam int FG    = GRAV << MASS_SHIFT;
    localparam int FG_BW = $clog2(FG + 1);
    localparam int F_W   = ((CUR_W > FG_BW) ? CUR_W : FG_BW) + 1;
    localparam int V_IN  = (VEL_W > ACC_W) ? VEL_W : ACC_W;
    localparam int HS_W  = ((H_W > VEL_W) ? H_W : VEL_W) + 2;

    localparam logic signed [F_W-1:0] FG_S   = F_W'(FG);
    localparam logic signed [F_W-1:0] NEG_FG = -FG_S;

    logic [CUR_W-1:0]        fm;
    logic signed [ACC_W-1:0] at;
    logic signed [VEL_W-1:0] vt;
    logic [H_W-1:0]          ht;

    // Acceleration from the registered force
    logic signed [F_W-1:0]   fm_s;
    logic signed [ACC_W-1:0] at_raw;
    logic signed [ACC_W-1:0] at_nxt;

    assign fm_s = F_W'({1'b0, fm});

    tray_sat_add #(.IN_W(F_W), .OUT_W(ACC_W), .SHIFT(MASS_SHIFT)) u_acc (
        .a (fm_s),
        .b (NEG_FG),
        .y (at_raw)
    );

    // A tray resting on a stop cannot be pushed further into it.
    always_comb begin
        at_nxt = at_raw;
        if ((at_floor && fm_s < FG_S) || (at_ceil && fm_s > FG_S))
            at_nxt = '0;
    end

    // Velocity
    logic signed [VEL_W-1:0] vt_base;
    logic signed [V_IN-1:0]  va;
    logic signed [V_IN-1:0]  vb;
    logic signed [VEL_W-1:0] vt_nxt;

`ifdef TRAY_DAMPING_EN
    // V - V/2^k shrinks magnitude, so only the acceleration add can overflow.
    assign vt_base = vt - (vt >>> DAMP_SHIFT);
`else
    assign vt_base = vt;
`endif

    assign va = V_IN'(vt_base);
    assign vb = V_IN'(at);

    tray_sat_add #(.IN_W(V_IN), .OUT_W(VEL_W), .SHIFT(0)) u_vel (
        .a (va),
        .b (vb),
        .y (vt_nxt)
    );

    // Height with clamp to [0, H_MAX]
    logic signed [HS_W-1:0] hs;
    logic signed [HS_W-1:0] hmax_s;
    logic [H_W-1:0]         ht_nxt;
    logic                   h_clamp;

    assign hmax_s = {{(HS_W - H_W){1'b0}}, H_MAX};
    assign hs     = HS_W'($signed({1'b0, ht})) + HS_W'(vt);

    always_comb begin
        ht_nxt  = hs[H_W-1:0];
        h_clamp = 1'b0;
        if (hs < 0) begin
            ht_nxt  = '0;
            h_clamp = 1'b1;
        end else if (hs > hmax_s) begin
            ht_nxt  = H_MAX;
            h_clamp = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fm <= '0;
            at <= '0;
            vt <= '0;
            ht <= '0;
        end else if (step) begin
            fm <= icou;
            at <= at_nxt;
            vt <= h_clamp ? '0 : vt_nxt;
            ht <= ht_nxt;
        end
    end

    // Motion state decoded from the registered height and velocity; stops win.
    tray_state_e st;

    always_comb begin
        st = HOVER;
        if (at_floor && (vt <= 0))
            st = FLOOR;
        else if (at_ceil && (vt >= 0))
            st = CEIL;
        else if (vt > 0)
            st = RISE;
        else if (vt < 0)
            st = FALL;
    end

    assign at_floor    = (ht == '0);
    assign at_ceil     = (ht == H_MAX);
    assign state       = st;
    assign tray_height = ht;
    assign tray_vel    = vt;
    assign tray_acc    = at;

endmodule
